// File: rtl/im2col_skew_gen_pkg.sv
// im2col_pkg: shared FSM states and line-buffer geometry helpers for im2col_skew_gen
package im2col_pkg;

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN} state_e;

  localparam int WIN = 9;

  // Line-buffer depth for a given image width: two full rows plus three pixels
  function automatic int lb_depth(input int width);
    return 2 * width + 3;
  endfunction

  // Buffer position of window tap (row, col), row 0 = top, col 0 = left; pos 0 is the newest pixel
  function automatic int tap_pos(input int row, input int col, input int width);
    return (2 - row) * width + (2 - col);
  endfunction

endpackage

// File: rtl/im2col_skew_gen_skew_delay_line.sv
// skew_delay_line: fixed-length register chain carrying one lane's {valid,data}
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] d_o
);

  logic [W-1:0] pipe_q [DEPTH];

  // shift the lane one stage per cycle; reset empties the whole chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign d_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/im2col_skew_gen.sv
// im2col_skew_gen: raster pixel stream to zero-padded 3x3 windows, lane j skewed by j cycles
module im2col_skew_gen
  import im2col_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int HEIGHT   = 128,
  parameter int CHANNEL  = 3,
  parameter int BITWIDTH = 8,
  parameter int PORT     = 27
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [CHANNEL*8-1:0]       i_pixel,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [PORT*BITWIDTH-1:0]   o_data,
  output logic [PORT-1:0]            o_valid,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int LB_N = lb_depth(WIDTH);
  localparam int PXW  = $clog2(NPIX);
  localparam int CXW  = $clog2(WIDTH);
  localparam int CYW  = $clog2(HEIGHT);
  localparam int DRW  = $clog2(PORT);
  localparam int NB   = BITWIDTH < 8 ? BITWIDTH : 8;
  localparam int PW   = CHANNEL * 8;

  state_e                   state_q;
  logic [PXW-1:0]           px_q;
  logic [CXW-1:0]           cx_q;
  logic [CYW-1:0]           cy_q;
  logic [DRW-1:0]           dr_q;
  logic                     done_q;
  logic [PW-1:0]            lb_q [LB_N-1];
  logic [PW-1:0]            lb_d [LB_N];
  logic [PORT*BITWIDTH-1:0] win_d;
  logic [PORT*BITWIDTH-1:0] win_q;
  logic                     win_v_q;
  logic                     acc;
  logic                     flush;
  logic                     emit;
  logic                     x_last;
  logic                     y_last;

  assign o_ready = state_q == FILL || state_q == RUN;
  assign o_busy  = state_q != IDLE;
  assign o_done  = done_q;
  assign acc     = i_valid && o_ready;
  assign flush   = state_q == FLUSH;
  assign emit    = (acc && state_q == RUN) || flush;
  assign x_last  = cx_q == CXW'(WIDTH - 1);
  assign y_last  = cy_q == CYW'(HEIGHT - 1);

  // buffer contents as they stand after this cycle's shift; the oldest entry needs no storage
  always_comb begin
    lb_d[0] = flush ? '0 : i_pixel;
    for (int p = 1; p < LB_N; p++) lb_d[p] = lb_q[p-1];
  end

  // gather the nine taps per channel, zeroing taps that fall outside the image
  always_comb begin
    win_d = '0;
    for (int c = 0; c < CHANNEL; c++)
      for (int r = 0; r < WIN; r++)
        if (!((r < 3 && cy_q == '0) || (r > 5 && y_last) ||
              (r % 3 == 0 && cx_q == '0) || (r % 3 == 2 && x_last)))
          win_d[(WIN*c+r)*BITWIDTH +: BITWIDTH] =
            BITWIDTH'(lb_d[tap_pos(r / 3, r % 3, WIDTH)][8*c+7 -: NB]);
  end

  // line buffer advances on every accepted pixel and on every flush cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < LB_N - 1; p++) lb_q[p] <= '0;
    end else if (acc || flush) begin
      for (int p = 0; p < LB_N - 1; p++) lb_q[p] <= lb_d[p];
    end
  end

  // lane-0 window register; idle cycles load zeros so invalid lanes stay zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q   <= '0;
      win_v_q <= 1'b0;
    end else begin
      win_q   <= emit ? win_d : '0;
      win_v_q <= emit;
    end
  end

  // frame sequencing plus the centre-pixel counters that drive edge masking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      px_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      dr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (acc) px_q <= px_q + 1'b1;
      if (emit) begin
        cx_q <= x_last ? '0 : cx_q + 1'b1;
        cy_q <= x_last ? cy_q + 1'b1 : cy_q;
      end
      case (state_q)
        IDLE: if (i_start) begin
          state_q <= FILL;
          px_q    <= '0;
          cx_q    <= '0;
          cy_q    <= '0;
        end
        FILL:  if (acc && px_q == PXW'(WIDTH)) state_q <= RUN;
        RUN:   if (acc && px_q == PXW'(NPIX - 1)) state_q <= FLUSH;
        FLUSH: if (x_last && y_last) begin
          state_q <= DRAIN;
          dr_q    <= '0;
        end
        DRAIN: begin
          dr_q <= dr_q + 1'b1;
          if (dr_q == DRW'(PORT - 2)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < PORT; j++) begin : g_lane
    logic [BITWIDTH:0] lane_in;
    logic [BITWIDTH:0] lane_out;
    assign lane_in = {win_v_q, win_q[j*BITWIDTH +: BITWIDTH]};
    if (j == 0) begin : g_direct
      assign lane_out = lane_in;
    end else begin : g_skew
      skew_delay_line #(.DEPTH(j), .W(BITWIDTH + 1)) u_dl (
        .clk(clk),
        .rst(rst),
        .d_i(lane_in),
        .d_o(lane_out)
      );
    end
    assign {o_valid[j], o_data[j*BITWIDTH +: BITWIDTH]} = lane_out;
  end

endmodule

// File: tb/tb_im2col_skew_gen.sv
// tb_im2col_skew_gen: scoreboard bench for the skewed im2col stream
module tb_im2col_skew_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int C    = 3;
  localparam int P    = 27;
  localparam int NPIX = W * H;
  localparam int NSP  = 25;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start;
  logic           i_valid;
  logic [C*8-1:0] i_pixel;
  logic           o_ready, o_busy, o_done;
  logic [P*8-1:0] o_data;
  logic [P-1:0]   o_valid;
  logic           r4, b4, d4, r12, b12, d12;
  logic [P*4-1:0]  o_data4;
  logic [P*12-1:0] o_data12;
  logic [P-1:0]   o_valid4, o_valid12;

  int n_chk = 0;
  int n_pass = 0;
  int mode = 0;
  int cyc = 0;
  int last_l0 = 0;
  int popped = 0;
  int idx;
  bit done_seen = 0;
  int nb [P];
  logic [P-1:0]   hist;
  logic [P*8-1:0] ew;
  logic [7:0]     ev;
  logic [P*8-1:0] sbq [$];

  int sp_k [NSP] = '{5,5,5,5,5,5,5,5,5,5, 0,0,0,0,0,0,0,0,0, 11,11,11,11,11,11};
  int sp_j [NSP] = '{0,1,2,3,4,5,6,7,8,13, 0,1,2,3,6,4,5,7,8, 2,5,6,7,8,4};
  int sp_v [NSP] = '{0,1,2,16,17,18,32,33,34,81, 0,0,0,0,0,0,1,16,17, 0,0,0,0,0,35};

  always #5 clk = ~clk;

  im2col_skew_gen #(.WIDTH(W), .HEIGHT(H), .CHANNEL(C), .BITWIDTH(8), .PORT(P)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_pixel(i_pixel), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
  );

  im2col_skew_gen #(.WIDTH(W), .HEIGHT(H), .CHANNEL(C), .BITWIDTH(4), .PORT(P)) u_bw4 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_pixel(i_pixel), .i_valid(i_valid),
    .o_ready(r4), .o_data(o_data4), .o_valid(o_valid4), .o_busy(b4), .o_done(d4)
  );

  im2col_skew_gen #(.WIDTH(W), .HEIGHT(H), .CHANNEL(C), .BITWIDTH(12), .PORT(P)) u_bw12 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_pixel(i_pixel), .i_valid(i_valid),
    .o_ready(r12), .o_data(o_data12), .o_valid(o_valid12), .o_busy(b12), .o_done(d12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] pix(input int y, input int x, input int c);
    return mode == 1 ? 8'hAB : 8'(16 * y + x + 64 * c);
  endfunction

  function automatic logic [C*8-1:0] pix_word(input int p);
    logic [C*8-1:0] w;
    for (int c = 0; c < C; c++) w[8*c +: 8] = pix(p / W, p % W, c);
    return w;
  endfunction

  function automatic logic [P*8-1:0] exp_win(input int k);
    logic [P*8-1:0] e;
    int r, c, y, x;
    e = '0;
    for (int j = 0; j < P; j++) begin
      r = j % 9;
      c = j / 9;
      y = k / W + r / 3 - 1;
      x = k % W + r % 3 - 1;
      if (y >= 0 && y < H && x >= 0 && x < W) e[j*8 +: 8] = pix(y, x, c);
    end
    return e;
  endfunction

  // output monitor: skew, zero-when-idle, scoreboard data, frame totals
  always @(negedge clk) begin
    cyc++;
    hist = {hist[P-2:0], o_valid[0]};
    for (int j = 0; j < P; j++) begin
      chk("skew_valid", 32'(o_valid[j]), 32'(hist[j]));
      if (!o_valid[j]) begin
        chk("idle_lane_zero", 32'(o_data[j*8 +: 8]), 0);
      end else begin
        idx = nb[j] - popped;
        chk("beat_in_frame", 32'(idx < sbq.size()), 1);
        if (idx < sbq.size()) begin
          ew = sbq[idx];
          ev = ew[j*8 +: 8];
          chk("lane_data", 32'(o_data[j*8 +: 8]), 32'(ev));
          if (mode == 0)
            for (int s = 0; s < NSP; s++)
              if (sp_k[s] == nb[j] && sp_j[s] == j) chk("spot_value", 32'(o_data[j*8 +: 8]), sp_v[s]);
          if (j == 4) begin
            chk("bw4_lane", 32'({o_valid4[4], o_data4[16 +: 4]}), 32'({1'b1, ev[7:4]}));
            chk("bw12_lane", 32'({o_valid12[4], o_data12[48 +: 12]}), 32'({1'b1, 4'h0, ev}));
            if (mode == 1 && nb[j] == 5) begin
              chk("bw4_centre", 32'(o_data4[16 +: 4]), 32'h0A);
              chk("bw12_centre", 32'(o_data12[48 +: 12]), 32'h0AB);
            end
          end
        end
        if (j == 0) last_l0 = cyc;
        nb[j]++;
        if (j == P - 1 && sbq.size() > 0) begin
          sbq.delete(0);
          popped++;
        end
      end
    end
    if (o_done) begin
      chk("done_latency", 32'(cyc - last_l0), P - 1);
      for (int j = 0; j < P; j++) chk("beats_per_lane", nb[j], NPIX);
      chk("busy_low_at_done", 32'(o_busy), 0);
      done_seen = 1;
    end
  end

  task automatic run_frame(input int gap, input int stop, input bit start_in_run);
    int p = 0;
    int guard = 0;
    bit sent = 0;
    sbq.delete();
    popped = 0;
    done_seen = 0;
    for (int j = 0; j < P; j++) nb[j] = 0;
    for (int k = 0; k < NPIX; k++) sbq.push_back(exp_win(k));
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 1);
    while (p < stop && guard < 2000) begin
      guard++;
      i_valid = $urandom_range(99) >= gap;
      i_pixel = pix_word(p);
      i_start = start_in_run && !sent && p == W + 3;
      sent = sent | i_start;
      if (i_valid && o_ready) p++;
      @(negedge clk);
    end
    i_start = 1'b0;
    chk("pixels_accepted", p, stop);
    if (stop == NPIX) begin
      guard = 0;
      while (!done_seen && guard < 200) begin
        guard++;
        i_valid = 1'b1;
        i_pixel = '1;
        chk("ready_low_after_input", 32'(o_ready), 0);
        @(negedge clk);
      end
      chk("done_seen", 32'(done_seen), 1);
      chk("scoreboard_empty", sbq.size(), 0);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_pixel = '0;
    hist = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(|o_data), 0);
    rst = 1'b1;
    mode = 0;
    run_frame(0, NPIX, 1'b1);
    run_frame(50, NPIX, 1'b0);
    mode = 1;
    run_frame(0, NPIX, 1'b0);
    mode = 0;
    run_frame(0, 8, 1'b0);
    chk("pre_reset_active", 32'(o_valid[0]), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 32'(o_valid), 0);
    chk("async_data", 32'(|o_data), 0);
    chk("async_ready", 32'(o_ready), 0);
    chk("async_busy", 32'(o_busy), 0);
    chk("async_done", 32'(o_done), 0);
    sbq.delete();
    hist = '0;
    popped = 0;
    #9 rst = 1'b1;
    run_frame(0, NPIX, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
